// File: rtl/stream_arb_mux.sv
// stream_arb_mux: N-to-1 valid/ready stream multiplexer with an internal
// round-robin arbiter and a registered output stage (1-cycle latency,
// 1 beat/cycle sustained throughput).
// Optional build macro STREAM_ARB_MUX_FIXED_PRIORITY_EN: replaces round-robin
// with fixed priority (lowest requesting index wins, no last-grant pointer).
module stream_arb_mux #(
  parameter  int WIDTH  = 32,
  parameter  int INPUTS = 4,
  localparam int SELW   = $clog2(INPUTS)
) (
  input  logic                    i_Clock,
  input  logic                    i_Reset,
  input  logic [INPUTS-1:0]       i_Valid,
  input  logic [INPUTS*WIDTH-1:0] i_Data,
  output logic [INPUTS-1:0]       o_Ready,
  output logic                    o_Valid,
  output logic [WIDTH-1:0]        o_Data,
  output logic [SELW-1:0]         o_Select,
  input  logic                    i_Ready
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SELW-1:0]  sel_q, sel_d;
`ifndef STREAM_ARB_MUX_FIXED_PRIORITY_EN
  logic [SELW-1:0]  last_q, last_d;
`endif

  logic             load;
  logic             grant_found;
  logic [SELW-1:0]  grant_idx;
  logic [WIDTH-1:0] grant_data;
  logic             xfer;

  // Output register can take a beat when empty or drained this cycle
  assign load = !valid_q || i_Ready;

  // Arbitration: pick the granted channel from the request vector only
  always_comb begin
    int unsigned cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
`ifdef STREAM_ARB_MUX_FIXED_PRIORITY_EN
    for (int unsigned k = 0; k < INPUTS; k++) begin
      if (!grant_found && i_Valid[SELW'(k)]) begin
        grant_found = 1'b1;
        grant_idx   = SELW'(k);
      end
    end
`else
    // Scan starts just after the last grant and wraps modulo INPUTS, so
    // indices >= INPUTS are never produced even for non-power-of-two sizes.
    for (int unsigned off = 1; off <= INPUTS; off++) begin
      cand = (32'(last_q) + off) % INPUTS;
      if (!grant_found && i_Valid[SELW'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = SELW'(cand);
      end
    end
`endif
  end

  // Data mux for the granted channel (kept separate so o_Ready never sees i_Data)
  always_comb begin
    grant_data = '0;
    for (int unsigned k = 0; k < INPUTS; k++) begin
      if (grant_idx == SELW'(k)) grant_data = i_Data[k*WIDTH +: WIDTH];
    end
  end

  // One-hot accept towards the granted producer; silent during reset
  always_comb begin
    o_Ready = '0;
    if (xfer) o_Ready[grant_idx] = 1'b1;
  end

  assign xfer = i_Reset && load && grant_found;

  // Next-state of the output stage and the last-grant pointer
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    sel_d   = sel_q;
`ifndef STREAM_ARB_MUX_FIXED_PRIORITY_EN
    last_d  = last_q;
`endif
    if (xfer) begin
      valid_d = 1'b1;
      data_d  = grant_data;
      sel_d   = grant_idx;
`ifndef STREAM_ARB_MUX_FIXED_PRIORITY_EN
      last_d  = grant_idx;
`endif
    end else if (valid_q && i_Ready) begin
      valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge i_Clock) begin
    if (!i_Reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
`ifndef STREAM_ARB_MUX_FIXED_PRIORITY_EN
      last_q  <= SELW'(INPUTS - 1);
`endif
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
`ifndef STREAM_ARB_MUX_FIXED_PRIORITY_EN
      last_q  <= last_d;
`endif
    end
  end

  assign o_Valid  = valid_q;
  assign o_Data   = data_q;
  assign o_Select = sel_q;

endmodule
